// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//   Pipeline-control block for the 5-stage RISC-V core. Each cycle it decides
//   which stages advance, hold or take a bubble. It watches for load-use
//   hazards, EX-stage redirects and instruction/data memory wait states. A
//   small FSM plus a wait-timeout counter follow multi-cycle data-memory
//   stalls and latch an unrecoverable bus fault.
//
//   Parameters
//     WAIT_TIMEOUT  consecutive wait cycles (imem or dmem) before FAULT, >= 2
//     CNT_W         width of the optional performance counters
//
//   Ports
//     clk, rst                        clock, synchronous active-high reset
//     mem_do_read_ctrl_ex             EX instruction is a load
//     wr_reg_idx_ex                   EX destination register
//     r1/r2_reg_idx_id, r1/r2_used_id ID source registers and their use flags
//     redirect_ex                     taken branch / jump resolved in EX
//     imem_ready                      fetch data valid this cycle
//     dmem_req_mem, dmem_ready        MEM access request / completion
//     pc_enable                       PC load enable
//     <stage>_enable, <stage>_clear   IF/ID, ID/EX, EX/MEM, MEM/WB controls
//     bus_fault                       sticky fault flag
//     ctrl_state                      0 RUN, 1 DWAIT, 2 FAULT
//
//   Optional feature, macro HAZARD_PERF_COUNTERS_EN:
//     stall_cycles, flush_count, load_use_count (CNT_W bits, saturating).
//
//   Stage controls are combinational from state and inputs, so a stall or
//   flush acts in the same cycle the hazard is seen.
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_do_read_ctrl_ex,
    input  logic [4:0]       wr_reg_idx_ex,
    input  logic [4:0]       r1_reg_idx_id,
    input  logic [4:0]       r2_reg_idx_id,
    input  logic             r1_used_id,
    input  logic             r2_used_id,
    input  logic             redirect_ex,
    input  logic             imem_ready,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_clear,
    output logic             id_ex_enable,
    output logic             id_ex_clear,
    output logic             ex_mem_enable,
    output logic             ex_mem_clear,
    output logic             mem_wb_enable,
    output logic             mem_wb_clear,
    output logic             bus_fault,
    output logic [1:0]       ctrl_state
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] load_use_count
`endif
);

    localparam int unsigned TMO_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(WAIT_TIMEOUT - 1);

    // Elaboration-time parameter sanity check.
    if (WAIT_TIMEOUT < 2 || CNT_W == 0) begin : g_bad_param
        $error("hazard_ctrl_unit: WAIT_TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] wcnt_q, wcnt_d;
    logic             bus_fault_q, bus_fault_d;

    logic load_use;
    logic dwait;
    logic any_wait;

    // Hazard detection. A write to x0 never creates a dependency.
    assign load_use = mem_do_read_ctrl_ex && (wr_reg_idx_ex != 5'd0) &&
                      ((r1_used_id && (r1_reg_idx_id == wr_reg_idx_ex)) ||
                       (r2_used_id && (r2_reg_idx_id == wr_reg_idx_ex)));
    assign dwait    = dmem_req_mem && !dmem_ready;
    assign any_wait = dwait || !imem_ready;

    // Next-state: FSM, wait-timeout counter and fault flag.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        bus_fault_d = bus_fault_q;
        case (state_q)
            ST_RUN, ST_DWAIT: begin
                // Timeout is judged on the count before this cycle's wait.
                if (any_wait && (wcnt_q == TMO_MAX)) begin
                    state_d = ST_FAULT;
                end else if (dwait) begin
                    state_d = ST_DWAIT;
                end else begin
                    state_d = ST_RUN;
                end
                if (!any_wait) begin
                    wcnt_d = '0;
                end else if (wcnt_q != TMO_MAX) begin
                    wcnt_d = wcnt_q + TMO_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
        bus_fault_d = (state_d == ST_FAULT);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            bus_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            bus_fault_q <= bus_fault_d;
        end
    end

    // Stage controls, highest-priority cause first.
    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_clear   = 1'b0;
        id_ex_enable  = 1'b1;
        id_ex_clear   = 1'b0;
        ex_mem_enable = 1'b1;
        ex_mem_clear  = 1'b0;
        mem_wb_enable = 1'b1;
        mem_wb_clear  = 1'b0;
        if (rst) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            if_id_clear   = 1'b1;
            id_ex_enable  = 1'b0;
            id_ex_clear   = 1'b1;
            ex_mem_enable = 1'b0;
            ex_mem_clear  = 1'b1;
            mem_wb_enable = 1'b0;
            mem_wb_clear  = 1'b1;
        end else if (state_q == ST_FAULT) begin
            // Freeze everything, keep contents for post-mortem.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
        end else if (dwait) begin
            // Hold up to MEM; WB retires a bubble so the stalled access
            // is not written back twice.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_clear  = 1'b1;
        end else if (redirect_ex) begin
            // IF and ID hold wrong-path instructions.
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID for one cycle, bubble into EX.
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_clear  = 1'b1;
        end else if (!imem_ready) begin
            pc_enable   = 1'b0;
            if_id_clear = 1'b1;
        end
    end

    assign bus_fault  = bus_fault_q && !rst;
    assign ctrl_state = state_q;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] lu_q, lu_d;
    logic             cnt_active;

    assign cnt_active = (state_q != ST_FAULT);

    // Saturating event counters; idle while frozen in FAULT.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        lu_d    = lu_q;
        if (cnt_active) begin
            if (!pc_enable && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (!dwait && redirect_ex && (flush_q != '1)) begin
                flush_d = flush_q + CNT_W'(1);
            end
            if (!dwait && !redirect_ex && load_use && (lu_q != '1)) begin
                lu_d = lu_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
            lu_q    <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            lu_q    <= lu_d;
        end
    end

    assign stall_cycles   = stall_q;
    assign flush_count    = flush_q;
    assign load_use_count = lu_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//   Directed bench for hazard_ctrl_unit with WAIT_TIMEOUT = 4. A stage-action
//   model (advance / hold / bubble per stage, chosen from the winning cause)
//   is checked against the DUT on every falling edge; literal checks in the
//   stimulus pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    localparam int unsigned WT = 4;
    localparam int unsigned CW = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_do_read_ctrl_ex;
    logic [4:0] wr_reg_idx_ex, r1_reg_idx_id, r2_reg_idx_id;
    logic       r1_used_id, r2_used_id, redirect_ex, imem_ready;
    logic       dmem_req_mem, dmem_ready;
    logic       pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear;
    logic       ex_mem_enable, ex_mem_clear, mem_wb_enable, mem_wb_clear;
    logic       bus_fault;
    logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CW-1:0] stall_cycles, flush_count, load_use_count;
`endif

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_do_read_ctrl_ex (mem_do_read_ctrl_ex),
        .wr_reg_idx_ex       (wr_reg_idx_ex),
        .r1_reg_idx_id       (r1_reg_idx_id),
        .r2_reg_idx_id       (r2_reg_idx_id),
        .r1_used_id          (r1_used_id),
        .r2_used_id          (r2_used_id),
        .redirect_ex         (redirect_ex),
        .imem_ready          (imem_ready),
        .dmem_req_mem        (dmem_req_mem),
        .dmem_ready          (dmem_ready),
        .pc_enable           (pc_enable),
        .if_id_enable        (if_id_enable),
        .if_id_clear         (if_id_clear),
        .id_ex_enable        (id_ex_enable),
        .id_ex_clear         (id_ex_clear),
        .ex_mem_enable       (ex_mem_enable),
        .ex_mem_clear        (ex_mem_clear),
        .mem_wb_enable       (mem_wb_enable),
        .mem_wb_clear        (mem_wb_clear),
        .bus_fault           (bus_fault),
        .ctrl_state          (ctrl_state)
`ifdef HAZARD_PERF_COUNTERS_EN
        ,
        .stall_cycles        (stall_cycles),
        .flush_count         (flush_count),
        .load_use_count      (load_use_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {ADV, HOLD, BUB} act_e;
    typedef enum int {C_NONE, C_RST, C_FAULT, C_DWAIT, C_REDIR, C_LU, C_IMEM} cause_e;

    bit     started = 1'b0;
    bit     m_fault = 1'b0;
    bit     m_dwait = 1'b0;
    int     m_run   = 0;
    longint m_stall = 0, m_flush = 0, m_lu = 0;
    string  nm [5] = '{"pc", "if_id", "id_ex", "ex_mem", "mem_wb"};

    function automatic bit id_reads(input logic [4:0] r);
        return (r1_used_id && r1_reg_idx_id == r) || (r2_used_id && r2_reg_idx_id == r);
    endfunction

    function automatic cause_e cause_now();
        if (rst)                              return C_RST;
        if (m_fault)                          return C_FAULT;
        if (dmem_req_mem && !dmem_ready)      return C_DWAIT;
        if (redirect_ex)                      return C_REDIR;
        if (mem_do_read_ctrl_ex && wr_reg_idx_ex != 5'd0 && id_reads(wr_reg_idx_ex))
                                              return C_LU;
        if (!imem_ready)                      return C_IMEM;
        return C_NONE;
    endfunction

    function automatic longint sat(input longint v);
        longint mx = (longint'(1) << CW) - 1;
        return (v >= mx) ? mx : v + 1;
    endfunction

    // Model state advances on the same edge as the DUT.
    always @(posedge clk) begin
        cause_e c;
        c = cause_now();
        if (rst) begin
            started = 1'b1;
            m_fault = 1'b0;
            m_dwait = 1'b0;
            m_run   = 0;
            m_stall = 0;
            m_flush = 0;
            m_lu    = 0;
        end else if (!m_fault) begin
            if (c == C_DWAIT || c == C_LU || c == C_IMEM) m_stall = sat(m_stall);
            if (c == C_REDIR) m_flush = sat(m_flush);
            if (c == C_LU)    m_lu    = sat(m_lu);
            if ((dmem_req_mem && !dmem_ready) || !imem_ready) m_run++;
            else m_run = 0;
            m_dwait = dmem_req_mem && !dmem_ready;
            if (m_run >= WT) m_fault = 1'b1;
        end
    end

    // Compare process: every falling edge once reset has been seen.
    always @(negedge clk) begin
        cause_e c;
        act_e   a  [5];
        logic   en [5];
        logic   cl [5];
        if (started) begin
            c = cause_now();
            case (c)
                C_RST:   a = '{HOLD, BUB,  BUB,  BUB,  BUB};
                C_FAULT: a = '{HOLD, HOLD, HOLD, HOLD, HOLD};
                C_DWAIT: a = '{HOLD, HOLD, HOLD, HOLD, BUB};
                C_REDIR: a = '{ADV,  BUB,  BUB,  ADV,  ADV};
                C_LU:    a = '{HOLD, HOLD, BUB,  ADV,  ADV};
                C_IMEM:  a = '{HOLD, BUB,  ADV,  ADV,  ADV};
                default: a = '{ADV,  ADV,  ADV,  ADV,  ADV};
            endcase
            en = '{pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable};
            cl = '{1'b0, if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear};
            for (int s = 0; s < 5; s++) begin
                if (s > 0) chk({"clr_", nm[s]}, longint'(cl[s]), longint'(a[s] == BUB));
                // Enable is don't-care under clear, except during reset.
                if (a[s] != BUB || c == C_RST)
                    chk({"en_", nm[s]}, longint'(en[s]), longint'(a[s] == ADV));
            end
            chk("state", longint'(ctrl_state), m_fault ? 2 : (m_dwait ? 1 : 0));
            chk("bus_fault", longint'(bus_fault), longint'(m_fault && !rst));
`ifdef HAZARD_PERF_COUNTERS_EN
            chk("stall_cycles", longint'(stall_cycles), m_stall);
            chk("flush_count", longint'(flush_count), m_flush);
            chk("load_use_count", longint'(load_use_count), m_lu);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        mem_do_read_ctrl_ex = 1'b0;
        wr_reg_idx_ex       = 5'd0;
        r1_reg_idx_id       = 5'd0;
        r2_reg_idx_id       = 5'd0;
        r1_used_id          = 1'b0;
        r2_used_id          = 1'b0;
        redirect_ex         = 1'b0;
        imem_ready          = 1'b1;
        dmem_req_mem        = 1'b0;
        dmem_ready          = 1'b1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        mid();
        chk("rst_pc_en", pc_enable, 0);
        chk("rst_if_id_clr", if_id_clear, 1);
        chk("rst_mem_wb_clr", mem_wb_clear, 1);
        chk("rst_mem_wb_en", mem_wb_enable, 0);
        chk("rst_bus_fault", bus_fault, 0);
        nxt(); nxt();

        rst = 1'b0;
        mid();
        chk("run_state", ctrl_state, 0);
        chk("run_pc_en", pc_enable, 1);
        chk("run_id_ex_clr", id_ex_clear, 0);
        nxt();

        // load x5 in EX, ID reads rs1 = x5: one bubble
        mem_do_read_ctrl_ex = 1'b1; wr_reg_idx_ex = 5'd5;
        r1_reg_idx_id = 5'd5; r1_used_id = 1'b1;
        mid();
        chk("lu_pc_en", pc_enable, 0);
        chk("lu_if_id_en", if_id_enable, 0);
        chk("lu_id_ex_clr", id_ex_clear, 1);
        chk("lu_ex_mem_en", ex_mem_enable, 1);
        nxt();
        mem_do_read_ctrl_ex = 1'b0;   // load has moved to MEM
        mid();
        chk("lu_after_pc_en", pc_enable, 1);
        chk("lu_after_if_id_en", if_id_enable, 1);
        chk("lu_after_id_ex_clr", id_ex_clear, 0);
        nxt();

        // load to x0: no hazard
        mem_do_read_ctrl_ex = 1'b1; wr_reg_idx_ex = 5'd0;
        r1_reg_idx_id = 5'd0; r1_used_id = 1'b1;
        mid();
        chk("x0_pc_en", pc_enable, 1);
        nxt();

        // rs2 matches but is unused: no hazard
        idle();
        mem_do_read_ctrl_ex = 1'b1; wr_reg_idx_ex = 5'd7;
        r2_reg_idx_id = 5'd7; r2_used_id = 1'b0;
        r1_reg_idx_id = 5'd3; r1_used_id = 1'b1;
        mid();
        chk("r2unused_pc_en", pc_enable, 1);
        chk("r2unused_id_ex_clr", id_ex_clear, 0);
        nxt();
        r2_used_id = 1'b1;
        mid();
        chk("r2used_pc_en", pc_enable, 0);
        chk("r2used_id_ex_clr", id_ex_clear, 1);
        nxt();

        // redirect overrides load-use
        idle();
        mem_do_read_ctrl_ex = 1'b1; wr_reg_idx_ex = 5'd9;
        r1_reg_idx_id = 5'd9; r1_used_id = 1'b1; redirect_ex = 1'b1;
        mid();
        chk("redir_pc_en", pc_enable, 1);
        chk("redir_if_id_clr", if_id_clear, 1);
        chk("redir_id_ex_clr", id_ex_clear, 1);
        chk("redir_ex_mem_en", ex_mem_enable, 1);
        nxt();

        // single imem wait, then redirect during imem wait
        idle();
        imem_ready = 1'b0;
        mid();
        chk("imem_pc_en", pc_enable, 0);
        chk("imem_if_id_clr", if_id_clear, 1);
        chk("imem_id_ex_en", id_ex_enable, 1);
        nxt();
        redirect_ex = 1'b1;
        mid();
        chk("imem_redir_pc_en", pc_enable, 1);
        nxt();
        idle();
        nxt();

        // three dmem wait cycles; redirect is ignored meanwhile
        dmem_req_mem = 1'b1; dmem_ready = 1'b0; redirect_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("dw_pc_en", pc_enable, 0);
            chk("dw_mem_wb_clr", mem_wb_clear, 1);
            chk("dw_if_id_clr", if_id_clear, 0);
            if (i > 0) chk("dw_state", ctrl_state, 1);
            nxt();
        end
        dmem_ready = 1'b1;
        mid();
        chk("dw_release_state", ctrl_state, 1);
        chk("dw_release_pc_en", pc_enable, 1);
        chk("dw_release_if_id_clr", if_id_clear, 1);
        nxt();
        idle();
        mid();
        chk("dw_done_state", ctrl_state, 0);
        nxt();

        // 3 waits, gap, 3 waits: counter clears, no fault
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        repeat (3) nxt();
        idle();
        nxt();
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        repeat (3) nxt();
        idle();
        nxt();
        mid();
        chk("gap_state", ctrl_state, 0);
        chk("gap_bus_fault", bus_fault, 0);
        nxt();

        // timeout on dmem: FAULT after the 4th wait cycle
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        repeat (4) nxt();
        mid();
        chk("flt_state", ctrl_state, 2);
        chk("flt_bus_fault", bus_fault, 1);
        chk("flt_pc_en", pc_enable, 0);
        chk("flt_mem_wb_en", mem_wb_enable, 0);
        chk("flt_mem_wb_clr", mem_wb_clear, 0);
        nxt();
        dmem_ready = 1'b1;
        mid();
        chk("flt_sticky", ctrl_state, 2);
        nxt();
        rst = 1'b1;
        mid();
        chk("flt_rst_bus_fault", bus_fault, 0);
        chk("flt_rst_id_ex_clr", id_ex_clear, 1);
        nxt();
        rst = 1'b0;
        idle();
        mid();
        chk("flt_rec_state", ctrl_state, 0);
        chk("flt_rec_bus_fault", bus_fault, 0);
        nxt();

        // timeout on imem
        imem_ready = 1'b0;
        repeat (4) nxt();
        mid();
        chk("iflt_state", ctrl_state, 2);
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        idle();
        nxt();

        // reset in the middle of a data stall
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        nxt(); nxt();
        rst = 1'b1;
        mid();
        chk("dwrst_if_id_clr", if_id_clear, 1);
        chk("dwrst_ex_mem_clr", ex_mem_clear, 1);
        chk("dwrst_pc_en", pc_enable, 0);
        nxt();
        rst = 1'b0;
        idle();
        mid();
        chk("dwrst_state", ctrl_state, 0);
`ifdef HAZARD_PERF_COUNTERS_EN
        chk("dwrst_stall_cycles", stall_cycles, 0);
        chk("dwrst_flush_count", flush_count, 0);
        chk("dwrst_load_use_count", load_use_count, 0);
`endif
        nxt();

        // mixed traffic, checked by the model
        for (int i = 0; i < 300; i++) begin
            rst                 = ((i % 60) == 59);
            mem_do_read_ctrl_ex = 1'($urandom_range(0, 1));
            wr_reg_idx_ex       = 5'($urandom_range(0, 3));
            r1_reg_idx_id       = 5'($urandom_range(0, 3));
            r2_reg_idx_id       = 5'($urandom_range(0, 3));
            r1_used_id          = 1'($urandom_range(0, 1));
            r2_used_id          = 1'($urandom_range(0, 1));
            redirect_ex         = ($urandom_range(0, 5) == 0);
            imem_ready          = ($urandom_range(0, 5) != 0);
            dmem_req_mem        = 1'($urandom_range(0, 1));
            dmem_ready          = ($urandom_range(0, 3) != 0);
            nxt();
        end
        idle();
        rst = 1'b0;
        nxt();
        mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central pipeline-control block for the 5-stage RISC-V core; drives the enable/clear inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards, branch/jump redirects and instruction/data memory wait states, and decides per cycle which stages advance, hold or take a bubble.
- A small FSM plus a wait-timeout counter tracks multi-cycle data-memory stalls and latches an unrecoverable bus fault.

Parameters:
- WAIT_TIMEOUT, 64: consecutive memory-wait cycles (imem or dmem) before entering FAULT; minimum 2.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_do_read_ctrl_ex  in  1  the instruction in EX is a load
- wr_reg_idx_ex  in  5  destination register of the instruction in EX
- r1_reg_idx_id  in  5  rs1 of the instruction in ID
- r2_reg_idx_id  in  5  rs2 of the instruction in ID
- r1_used_id  in  1  the instruction in ID reads rs1
- r2_used_id  in  1  the instruction in ID reads rs2
- redirect_ex  in  1  taken branch or jump resolved in EX
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req_mem  in  1  MEM stage performs a load/store this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_enable  out  1  PC register load enable
- if_id_enable, if_id_clear  out  1 each  IF/ID controls
- id_ex_enable, id_ex_clear  out  1 each  ID/EX controls
- ex_mem_enable, ex_mem_clear  out  1 each  EX/MEM controls
- mem_wb_enable, mem_wb_clear  out  1 each  MEM/WB controls
- bus_fault  out  1  sticky fault flag
- ctrl_state  out  2  FSM state: 0 RUN, 1 DWAIT, 2 FAULT

Behaviour:
- The FSM state, wait counter and bus_fault are registered. Control outputs are combinational from state and inputs, so they take effect in the same cycle.
- Reset: while rst=1, all enables are 0, all clears are 1 and bus_fault is 0. On the next edge the state is RUN, the counter is 0 and the optional counters are 0. Reset applied mid-stall or in FAULT returns to RUN.
- Default, RUN with no hazard: all enables are 1 and all clears are 0.
- load_use = mem_do_read_ctrl_ex and wr_reg_idx_ex != 0 and ((r1_used_id and r1_reg_idx_id == wr_reg_idx_ex) or (r2_used_id and r2_reg_idx_id == wr_reg_idx_ex)).
- dwait = dmem_req_mem and not dmem_ready.
- Priority, highest first:
  1. state FAULT: all enables 0, all clears 0 (pipeline frozen, contents preserved).
  2. dwait: all enables 0 except mem_wb_enable; mem_wb_clear = 1 (bubble into WB). Redirect and load-use are ignored this cycle; they are re-evaluated once the stall ends.
  3. redirect_ex: pc_enable = 1, if_id_clear = 1, id_ex_clear = 1; EX/MEM and MEM/WB advance. This overrides load-use, because the ID instruction is wrong-path, and overrides an imem wait.
  4. load_use: pc_enable = 0, if_id_enable = 0 (hold), id_ex_clear = 1; EX/MEM and MEM/WB advance. Exactly one bubble per hazard, since the load moves to MEM on the next cycle.
  5. not imem_ready: pc_enable = 0, if_id_clear = 1; downstream stages advance.
- Whenever a clear is 1, the matching enable is don't-care, because clear dominates inside the pipeline registers.
- FSM transitions:
  - RUN to DWAIT when dwait.
  - DWAIT to RUN on the cycle dmem_ready = 1; that cycle releases the stall (outputs as RUN).
  - RUN or DWAIT to FAULT when the wait counter reaches WAIT_TIMEOUT-1 while a wait (dwait, or not imem_ready) is still active.
  - FAULT persists until rst. bus_fault = 1 in FAULT.
- Wait counter:
  - Increments each cycle a wait is active.
  - Clears on any cycle with no wait.
  - Saturates at WAIT_TIMEOUT-1.
  - Width is clog2(WAIT_TIMEOUT).

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- When defined, three extra outputs exist, each CNT_W bits, saturating at all-ones, reset to 0, counting only in RUN/DWAIT:
  - stall_cycles: cycles with pc_enable = 0.
  - flush_count: cycles with redirect_ex acted on.
  - load_use_count: load-use bubbles inserted.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load x5 in EX (wr=5), ID reads rs1=5 with r1_used_id=1, memories ready -> one cycle with pc_enable=0, if_id_enable=0, id_ex_clear=1; the next cycle returns to all enables 1.
- Same as above but wr_reg_idx_ex=0, or r2 match with r2_used_id=0 -> no stall.
- redirect_ex=1 together with load_use=1 -> if_id_clear=1, id_ex_clear=1, pc_enable=1, no hold.
- dmem_req_mem=1 with dmem_ready low for 3 cycles -> ctrl_state=1, all enables 0 except mem_wb_enable, mem_wb_clear=1 for those 3 cycles; back to RUN with normal flow when ready=1.
- WAIT_TIMEOUT=4 with dmem_ready held 0 -> ctrl_state=2 and bus_fault=1 after the 4th wait cycle; all enables 0; rst returns to RUN with bus_fault=0.
- rst asserted during DWAIT -> all clears 1 while rst=1; RUN, counter 0 and perf counters 0 afterward.
